// File: rtl/arith_pkg.sv
// Shared arithmetic-library package: sequencer states and counter sizing helper.
package arith_pkg;

  // Sequencer states for the bit-serial arithmetic blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count 0..width-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out are pure functions of the three input bits.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock, start/done handshake.
// Optional signed-overflow output OVF is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned     CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LastCnt = CW'(WIDTH - 1);

  state_e           r_state, w_state_n;
  logic [WIDTH-1:0] r_a, w_a_n;
  logic [WIDTH-1:0] r_b, w_b_n;
  logic [WIDTH-1:0] r_work, w_work_n;
  logic             r_bw, w_bw_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [WIDTH-1:0] r_diff, w_diff_n;
  logic             r_borrow, w_borrow_n;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf, w_ovf_n;
`endif

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_work_shift;

  full_subtractor u_full_subtractor (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bout)
  );

  // New difference bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
  assign w_work_shift = {w_d, r_work[WIDTH-1:1]};

  // Next-state and datapath update; IDLE and DONE both accept a new request.
  always_comb begin
    w_state_n  = r_state;
    w_a_n      = r_a;
    w_b_n      = r_b;
    w_work_n   = r_work;
    w_bw_n     = r_bw;
    w_cnt_n    = r_cnt;
    w_diff_n   = r_diff;
    w_borrow_n = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
    w_ovf_n    = r_ovf;
`endif
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          w_state_n = ST_RUN;
          w_a_n     = A;
          w_b_n     = B;
          w_bw_n    = BIN;
          w_work_n  = '0;
          w_cnt_n   = '0;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_a_n    = r_a >> 1;
        w_b_n    = r_b >> 1;
        w_bw_n   = w_bout;
        w_work_n = w_work_shift;
        if (r_cnt == LastCnt) begin
          // Last bit: publish the result so it is valid while DONE is high.
          w_state_n  = ST_DONE;
          w_cnt_n    = '0;
          w_diff_n   = w_work_shift;
          w_borrow_n = w_bout;
`ifdef SERIAL_SUB_OVF_EN
          // r_bw is the borrow entering the MSB on this final bit.
          w_ovf_n    = r_bw ^ w_bout;
`endif
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_bw     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_a      <= w_a_n;
      r_b      <= w_b_n;
      r_work   <= w_work_n;
      r_bw     <= w_bw_n;
      r_cnt    <= w_cnt_n;
      r_diff   <= w_diff_n;
      r_borrow <= w_borrow_n;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= w_ovf_n;
`endif
    end
  end

  // Handshake flags decode directly from the state register.
  always_comb begin
    BUSY   = (r_state == ST_RUN);
    DONE   = (r_state == ST_DONE);
    DIFF   = r_diff;
    BORROW = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
    OVF    = r_ovf;
`endif
  end

endmodule
